// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock over N cycles, unsigned N-bit operands.
// Optional macro DIV_BY_ZERO_CHECK_EN: a zero divisor skips the iterations and raises div_by_zero.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   state_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  dvsr_q, dvsr_d;
    logic [N:0]    rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          zero_skip;
    logic [N+1:0]  shifted;
    logic [N+1:0]  trial;

`ifdef DIV_BY_ZERO_CHECK_EN
    assign zero_skip = (divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // The partial remainder never exceeds the divisor, so the extra top bit of
    // shifted is always 0 and trial[N+1] is the borrow of the trial subtraction.
    assign shifted = {rem_q, quot_q[N-1]};
    assign trial   = shifted - {2'b00, dvsr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    dvsr_d = divisor;
                    dz_d   = zero_skip;
                    if (zero_skip) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = {1'b0, dividend};
                    end else begin
                        state_d = CALC;
                        quot_d  = dividend;
                        rem_d   = '0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (!trial[N+1]) begin
                    rem_d  = trial[N:0];
                    quot_d = {quot_q[N-2:0], 1'b1};
                end else begin
                    rem_d  = shifted[N:0];
                    quot_d = {quot_q[N-2:0], 1'b0};
                end
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q[N-1:0];
    assign div_by_zero = dz_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (N=8): latency, results, start masking, reset abort, back-to-back runs.
module tb_shift_sub_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   state_o;

    int passed;
    int total;

    shift_sub_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Pulse start for one edge, then count edges until done (bounded); busy samples include the start edge.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output int busy_cnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    int lat;
    int bcnt;
    int gap;
    int done_seen;

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quot", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        check("rst_dz", 32'(div_by_zero), 0);
        check("rst_state", 32'(state_o), 0);
        rst = 1'b0;
        tick();

        // 100 / 7
        run_div(8'd100, 8'd7, lat, bcnt);
        check("b100_lat", 32'(lat), 8);
        check("b100_busy_cycles", 32'(bcnt), 9);
        check("b100_quot", 32'(quotient), 14);
        check("b100_rem", 32'(remainder), 2);
        check("b100_dz", 32'(div_by_zero), 0);
        tick();
        check("b100_done_pulse", 32'(done), 0);
        check("b100_busy_idle", 32'(busy), 0);
        check("b100_hold_quot", 32'(quotient), 14);
        check("b100_hold_rem", 32'(remainder), 2);
        tick();

        run_div(8'd255, 8'd1, lat, bcnt);
        check("b255_lat", 32'(lat), 8);
        check("b255_quot", 32'(quotient), 255);
        check("b255_rem", 32'(remainder), 0);
        tick();

        run_div(8'd5, 8'd9, lat, bcnt);
        check("b5_lat", 32'(lat), 8);
        check("b5_quot", 32'(quotient), 0);
        check("b5_rem", 32'(remainder), 5);
        tick();

        run_div(8'd200, 8'd0, lat, bcnt);
`ifdef DIV_BY_ZERO_CHECK_EN
        check("dz_lat", 32'(lat), 0);
        check("dz_flag", 32'(div_by_zero), 1);
`else
        check("dz_lat", 32'(lat), 8);
        check("dz_flag", 32'(div_by_zero), 0);
`endif
        check("dz_quot", 32'(quotient), 255);
        check("dz_rem", 32'(remainder), 200);
        tick();
        check("dz_hold_quot", 32'(quotient), 255);

        // start pulse with other operands while busy must be ignored
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("ign_dz_cleared", 32'(div_by_zero), 0);
        tick();
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("ign_lat", 32'(lat), 8);
        check("ign_quot", 32'(quotient), 14);
        check("ign_rem", 32'(remainder), 2);
        tick();

        // asynchronous reset in the middle of CALC
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quot", 32'(quotient), 0);
        check("abort_rem", 32'(remainder), 0);
        check("abort_state", 32'(state_o), 0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 0);
        run_div(8'd81, 8'd9, lat, bcnt);
        check("b81_lat", 32'(lat), 8);
        check("b81_quot", 32'(quotient), 9);
        check("b81_rem", 32'(remainder), 0);
        tick();

        // start held high across two back-to-back divisions
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("held1_lat", 32'(lat), 8);
        check("held1_quot", 32'(quotient), 14);
        check("held1_rem", 32'(remainder), 2);
        dividend = 8'd60;
        divisor  = 8'd8;
        gap = 0;
        tick();
        gap++;
        while (!done && gap < 30) begin
            tick();
            gap++;
        end
        start = 1'b0;
        check("held2_gap", 32'(gap), 10);
        check("held2_quot", 32'(quotient), 7);
        check("held2_rem", 32'(remainder), 4);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
- REQ-001: The block SHALL have parameter N, default 8, giving the operand width in bits; legal values are N >= 2.
- REQ-002: Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
- REQ-003: Port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004: Port start, input, 1 bit: request to begin a division; sampled only in IDLE.
- REQ-005: Port dividend, input, N bits: unsigned dividend; sampled on the accepted start edge.
- REQ-006: Port divisor, input, N bits: unsigned divisor; sampled on the accepted start edge.
- REQ-007: Port busy, output, 1 bit: high while a division is in progress, through the done cycle.
- REQ-008: Port done, output, 1 bit: one-cycle pulse marking valid results.
- REQ-009: Port quotient, output, N bits: unsigned quotient.
- REQ-010: Port remainder, output, N bits: unsigned remainder.
- REQ-011: Port div_by_zero, output, 1 bit: result flag for a zero divisor (see Configuration).

Function
- REQ-012: The FSM SHALL have three states:
  - IDLE -> CALC on start=1.
  - CALC -> DONE when the iteration counter reaches N-1.
  - DONE -> IDLE unconditionally.
- REQ-013: On an accepted start, the block SHALL load the dividend into the quotient/shift register, the divisor into the divisor register, clear the (N+1)-bit partial remainder, and clear the counter.
- REQ-014: Each CALC cycle SHALL perform one restoring step:
  - Shift {partial remainder, quotient register} left by one.
  - Compute trial = partial remainder - {1'b0, divisor}.
  - If trial is non-negative, the partial remainder becomes trial and the quotient LSB is 1; otherwise the partial remainder is restored and the quotient LSB is 0.
- REQ-015: Exactly N CALC cycles SHALL occur; done is high in the cycle N+1 clocks after the start edge.
- REQ-016: quotient and remainder SHALL be valid in the done cycle and hold until the next accepted start.
- REQ-017: busy SHALL be 1 in CALC and DONE and 0 in IDLE.
- REQ-018: start SHALL be ignored while busy=1, including in the DONE cycle; operands captured earlier are not disturbed.
- REQ-019: start held high continuously SHALL begin a new division on the first IDLE cycle after DONE.
- REQ-020: For divisor != 0, results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
- REQ-021: If dividend < divisor, then quotient = 0 and remainder = dividend.

Reset
- REQ-022: Asserting rst SHALL immediately force:
  - state = IDLE;
  - busy, done, div_by_zero = 0;
  - quotient, remainder, counter and internal registers = 0.
- REQ-023: Reset asserted mid-CALC SHALL abort the division; no done pulse follows, and the first accepted start after rst deasserts behaves as from power-up.

Configuration
- REQ-024: With the macro DIV_BY_ZERO_CHECK_EN defined, a divisor of 0 at start SHALL have this effect:
  - the FSM goes IDLE -> DONE directly, skipping CALC;
  - done is high 1 clock after the start edge;
  - quotient = all ones, remainder = dividend, div_by_zero = 1 in that cycle, with div_by_zero held with the results.
- REQ-025: Without DIV_BY_ZERO_CHECK_EN, a zero divisor SHALL run the normal N-cycle sequence, naturally yielding quotient = all ones and remainder = dividend; div_by_zero SHALL be tied to 0.
- REQ-026: div_by_zero SHALL clear on the next accepted start.

Verification (N=8)
- REQ-027: dividend=100, divisor=7, start for 1 cycle -> done 9 clocks later, quotient=14, remainder=2, busy high for 9 cycles.
- REQ-028: Test both boundary pairs:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
- REQ-029: 200/0 with DIV_BY_ZERO_CHECK_EN -> done 1 clock after start, quotient=255, remainder=200, div_by_zero=1; without the macro -> done after 9 clocks, same quotient and remainder, div_by_zero=0.
- REQ-030: Start 100/7, then pulse start with 50/5 at clock 4 -> ignored; results are 14/2.
- REQ-031: Start 100/7, assert rst at clock 5 -> all outputs 0 immediately, no done; then 81/9 -> quotient=9, remainder=0.
- REQ-032: start held high across two runs (100/7, then 60/8) -> the second done arrives exactly 10 clocks after the first, with quotient=7, remainder=4.
